match_phase_sched: RTL and testbench

- Sequences the phase-match compare tree for one row of candidate windows.
- Admits search requests from upstream and gates the tree's valid input. Tracks the tag of each in-flight window, because the tree carries no tag and has no backpressure.
- Re-attaches tags to tree results and applies a match threshold.
- Buffers results behind a valid/ready output and uses credits so the buffer cannot overflow.

---
 rtl/match_phase_sched_if.sv | 30 +++
 rtl/match_phase_sched.sv | 142 ++++++++++++++
 tb/tb_match_phase_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_phase_sched_if.sv
// Request/result handshake bundle for the phase-match scheduler.
// Master is the upstream/downstream side, slave is the scheduler.
interface match_phase_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 12
);
    logic                  req_vld;
    logic                  req_rdy;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  req_last;
    logic                  res_vld;
    logic                  res_rdy;
    logic [TAG_WIDTH-1:0]  res_tag;
    logic [DATA_WIDTH-1:0] res_pos;
    logic [DATA_WIDTH-1:0] res_error;
    logic                  res_hit;
    logic                  res_last;

    modport master (
        output req_vld, req_tag, req_last, res_rdy,
        input  req_rdy, res_vld, res_tag, res_pos,
        input  res_error, res_hit, res_last
    );

    modport slave (
        input  req_vld, req_tag, req_last, res_rdy,
        output req_rdy, res_vld, res_tag, res_pos,
        output res_error, res_hit, res_last
    );
endinterface

// File: rtl/match_phase_sched.sv
// Phase-match tree sequencer: admits windows, tracks tags across the
// fixed-latency tree, thresholds results and buffers them on credit.
module match_phase_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 12,
    parameter int TREE_LAT   = 21,
    parameter int RES_DEPTH  = 32,
    parameter int THRESH     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    match_phase_sched_if.slave    bus,
    output logic                  tree_vld_o,
    input  logic                  tree_vld_i,
    input  logic [DATA_WIDTH-1:0] tree_error,
    input  logic [DATA_WIDTH-1:0] tree_pos,
    output logic                  busy,
    output logic                  done,
    output logic                  err_orphan
);
    localparam int AW = $clog2(RES_DEPTH);
    localparam int FW = $clog2(TREE_LAT + 2);
    localparam logic [AW:0] P_ONE = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(RES_DEPTH);
    localparam logic [FW-1:0] FLUSH_C = FW'(TREE_LAT + 1);
    localparam logic [DATA_WIDTH:0] THRESH_C = (DATA_WIDTH+1)'(THRESH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic                  last;
        logic [DATA_WIDTH-1:0] pos;
        logic [DATA_WIDTH-1:0] error;
        logic                  hit;
    } res_t;

    state_t state, state_nx;
    logic [AW:0] outstanding;
    logic [AW:0] tag_wr, tag_rd, res_wr, res_rd;
    logic [FW-1:0] flush_cnt;
    logic [TAG_WIDTH:0] tag_mem [RES_DEPTH];
    res_t res_mem [RES_DEPTH];
    logic [TAG_WIDTH:0] tag_head;
    logic [DATA_WIDTH:0] err_ext, err_abs;
    res_t res_in, res_head;
    logic accept, res_pop, tree_take, clear;
    logic tag_empty, res_empty, flushing;

    assign flushing  = state == FLUSH;
    assign tag_empty = tag_wr == tag_rd;
    assign res_empty = res_wr == res_rd;

    assign bus.req_rdy = (state == RUN) && !abort
                       && (outstanding < DEPTH_C);
    assign accept     = bus.req_vld && bus.req_rdy;
    assign tree_vld_o = accept;
    assign busy       = state != IDLE;

    assign bus.res_vld = !res_empty && !flushing;
    assign res_pop     = bus.res_vld && bus.res_rdy;
    // Results landing during a flush belong to the cancelled row.
    assign tree_take   = tree_vld_i && !tag_empty && !flushing;
    assign clear       = flushing && (flush_cnt == '0);

    // One extra bit so the most negative error does not wrap.
    assign err_ext  = {tree_error[DATA_WIDTH-1], tree_error};
    assign err_abs  = err_ext[DATA_WIDTH] ? -err_ext : err_ext;
    assign tag_head = tag_mem[tag_rd[AW-1:0]];
    assign res_in   = {tag_head, tree_pos, tree_error,
                       err_abs <= THRESH_C};

    assign res_head      = res_mem[res_rd[AW-1:0]];
    assign bus.res_tag   = res_head.tag;
    assign bus.res_last  = res_head.last;
    assign bus.res_pos   = res_head.pos;
    assign bus.res_error = res_head.error;
    assign bus.res_hit   = res_head.hit;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN: begin
                if (abort) state_nx = FLUSH;
                else if (accept && bus.req_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (abort) state_nx = FLUSH;
                else if (outstanding == '0) state_nx = IDLE;
            end
            FLUSH: if (flush_cnt == '0) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            done       <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == DRAIN) && (state_nx == IDLE);
            if (tree_vld_i && tag_empty && !flushing)
                err_orphan <= 1'b1;
            if (!flushing && state_nx == FLUSH)
                flush_cnt <= FLUSH_C;
            else if (flushing && flush_cnt != '0)
                flush_cnt <= flush_cnt - FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tag_wr      <= '0;
            tag_rd      <= '0;
            res_wr      <= '0;
            res_rd      <= '0;
            outstanding <= '0;
        end else begin
            if (accept)    tag_wr <= tag_wr + P_ONE;
            if (tree_take) tag_rd <= tag_rd + P_ONE;
            if (tree_take) res_wr <= res_wr + P_ONE;
            if (res_pop)   res_rd <= res_rd + P_ONE;
            unique case ({accept, res_pop})
                2'b10:   outstanding <= outstanding + P_ONE;
                2'b01:   outstanding <= outstanding - P_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_mem[tag_wr[AW-1:0]] <= {bus.req_tag, bus.req_last};
        if (tree_take)
            res_mem[res_wr[AW-1:0]] <= res_in;
    end
endmodule

// File: tb/tb_match_phase_sched.sv
// Randomized bench for match_phase_sched against a row-level
// reference model of requests, tree latency, results and credits.
module tb_match_phase_sched;
    localparam int DW    = 16;
    localparam int TW    = 12;
    localparam int LAT   = 21;
    localparam int DEPTH = 32;
    localparam int THR   = 64;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_FLUSH = 3;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic tree_vld_o, tree_vld_i;
    logic [DW-1:0] tree_error, tree_pos;
    logic busy, done, err_orphan;

    match_phase_sched_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    match_phase_sched #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TREE_LAT(LAT),
        .RES_DEPTH(DEPTH), .THRESH(THR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bus(bus), .tree_vld_o(tree_vld_o),
        .tree_vld_i(tree_vld_i), .tree_error(tree_error),
        .tree_pos(tree_pos), .busy(busy), .done(done),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    // Fixed-latency tree: window data rides alongside its valid.
    logic [DW-1:0] win_err, win_pos, inj_err;
    logic inj;
    logic pv [LAT];
    logic [DW-1:0] pe [LAT];
    logic [DW-1:0] pp [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= tree_vld_o;
            pe[0] <= win_err;
            pp[0] <= win_pos;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pp[i] <= pp[i-1];
            end
        end
    end

    assign tree_vld_i = pv[LAT-1] | inj;
    assign tree_error = inj ? inj_err : pe[LAT-1];
    assign tree_pos   = pp[LAT-1];

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    typedef struct {
        logic [TW-1:0] tag;
        logic          last;
        logic [DW-1:0] pos;
        logic [DW-1:0] err;
        logic          hit;
        int            ready;
    } exp_t;

    exp_t q[$];
    int ncyc = 0;
    int mode = M_IDLE;
    int m_out = 0;
    int flush_left = 0;
    bit m_done = 0;
    bit m_orph = 0;

    // Row-level model, evaluated once per cycle on the falling edge.
    task automatic model_cycle();
        logic e_rdy, e_acc, e_vld, e_pop;
        exp_t it;
        int e;
        ncyc++;
        if (rst) begin
            mode = M_IDLE; m_out = 0; flush_left = 0;
            m_done = 0; m_orph = 0; q.delete();
            return;
        end
        e_rdy = (mode == M_RUN) && !abort && (m_out < DEPTH);
        e_acc = bus.req_vld && e_rdy;
        e_vld = (mode != M_FLUSH) && (q.size() > 0)
              && (q[0].ready <= ncyc);
        e_pop = e_vld && bus.res_rdy;
        check("req_rdy", bus.req_rdy, e_rdy);
        check("tree_vld_o", tree_vld_o, e_acc);
        check("res_vld", bus.res_vld, e_vld);
        check("busy", busy, mode != M_IDLE);
        check("done", done, m_done);
        check("err_orphan", err_orphan, m_orph);
        if (done) n_done++;
        if (e_vld) begin
            check("res_tag", bus.res_tag, q[0].tag);
            check("res_last", bus.res_last, q[0].last);
            check("res_pos", bus.res_pos, q[0].pos);
            check("res_error", bus.res_error, q[0].err);
            check("res_hit", bus.res_hit, q[0].hit);
        end
        if (inj && mode != M_FLUSH && q.size() == 0) m_orph = 1;
        if (e_acc) begin
            it.tag = bus.req_tag;
            it.last = bus.req_last;
            it.pos = win_pos;
            it.err = win_err;
            e = int'($signed(win_err));
            it.hit = ((e < 0) ? -e : e) <= THR;
            it.ready = ncyc + LAT + 1;
            q.push_back(it);
        end
        if (e_pop) void'(q.pop_front());
        m_done = 0;
        case (mode)
            M_IDLE: if (start) mode = M_RUN;
            M_RUN: begin
                if (abort) begin
                    mode = M_FLUSH; flush_left = LAT + 2;
                end else if (e_acc && bus.req_last) mode = M_DRAIN;
            end
            M_DRAIN: begin
                if (abort) begin
                    mode = M_FLUSH; flush_left = LAT + 2;
                end else if (m_out == 0) begin
                    mode = M_IDLE; m_done = 1;
                end
            end
            default: begin
                flush_left--;
                if (flush_left == 0) begin
                    mode = M_IDLE; q.delete(); m_out = 0;
                end
            end
        endcase
        m_out += int'(e_acc) - int'(e_pop);
    endtask

    initial forever begin
        @(negedge clk);
        model_cycle();
    end

    logic [DW-1:0] err_tab[$];

    function automatic logic [DW-1:0] pick_err();
        case ($urandom_range(0, 6))
            0: return 16'd64;
            1: return 16'hFFC0;
            2: return 16'd65;
            3: return 16'hFFBF;
            4: return 16'h8000;
            5: return DW'($urandom_range(0, 200));
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        inj = 1'b0;
    endtask

    task automatic new_window(input logic last);
        bus.req_tag = TW'($urandom);
        bus.req_last = last;
        win_pos = DW'($urandom);
        win_err = (err_tab.size() > 0) ? err_tab.pop_front()
                                       : pick_err();
    endtask

    task automatic cyc(input int vld_pct, input int rdy_pct,
                       output logic acc);
        bus.req_vld = $urandom_range(1, 100) <= vld_pct;
        if (rdy_pct >= 0)
            bus.res_rdy = $urandom_range(1, 100) <= rdy_pct;
        @(negedge clk);
        acc = bus.req_vld && bus.req_rdy;
        step();
    endtask

    task automatic run_row(input int n, input int vp, input int rp,
                           input int abort_at, output int sent);
        logic acc;
        bit stop;
        sent = 0;
        stop = 0;
        start = 1'b1;
        step();
        new_window(n == 1);
        for (int b = 0; b < 4000 && sent < n && !stop; b++) begin
            if (sent == abort_at) abort = 1'b1;
            cyc(vp, rp, acc);
            if (sent == abort_at) stop = 1;
            else if (acc) begin
                sent++;
                if (sent < n) new_window(sent == n - 1);
            end
        end
        bus.req_vld = 1'b0;
        if (abort_at < 0) check("row_sent", sent, n);
    endtask

    task automatic wait_idle(input int rdy_pct);
        bit idle;
        idle = 0;
        bus.req_vld = 1'b0;
        for (int b = 0; b < 3000 && !idle; b++) begin
            bus.res_rdy = $urandom_range(1, 100) <= rdy_pct;
            @(negedge clk);
            idle = !busy;
            step();
        end
        check("wait_idle", idle, 1);
    endtask

    initial begin
        int sent, d0, n, ab;
        logic acc;
        rst = 1'b1; start = 1'b0; abort = 1'b0; inj = 1'b0;
        inj_err = '0; win_err = '0; win_pos = '0;
        bus.req_vld = 1'b0; bus.req_tag = '0;
        bus.req_last = 1'b0; bus.res_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_rdy", bus.req_rdy, 0);
        check("rst_res_vld", bus.res_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_orphan", err_orphan, 0);
        step();

        // single window
        d0 = n_done;
        start = 1'b1;
        step();
        bus.req_tag = 12'd5; bus.req_last = 1'b1;
        win_err = 16'hFFF6; win_pos = 16'd37;
        bus.res_rdy = 1'b1;
        cyc(100, 100, acc);
        check("single_acc", acc, 1);
        wait_idle(100);
        check("single_done", n_done - d0, 1);

        // threshold edges
        err_tab.push_back(16'd64);
        err_tab.push_back(16'hFFC0);
        err_tab.push_back(16'd65);
        err_tab.push_back(16'h8000);
        run_row(4, 100, 100, -1, sent);
        wait_idle(100);

        // backpressure: credits cap the row at the buffer depth
        bus.res_rdy = 1'b0;
        start = 1'b1;
        step();
        new_window(1'b0);
        sent = 0;
        for (int b = 0; b < 80; b++) begin
            cyc(100, -1, acc);
            if (acc) begin sent++; new_window(sent == 39); end
        end
        check("bp_sent", sent, 32);
        @(negedge clk);
        check("bp_rdy", bus.req_rdy, 0);
        step();
        for (int b = 0; b < 400 && sent < 40; b++) begin
            cyc(100, 100, acc);
            if (acc) begin
                sent++;
                if (sent < 40) new_window(sent == 39);
            end
        end
        bus.req_vld = 1'b0;
        check("bp_total", sent, 40);
        wait_idle(100);

        // abort with ten windows in flight, then a clean row
        d0 = n_done;
        run_row(20, 100, 100, 10, sent);
        wait_idle(100);
        check("abort_done", n_done - d0, 0);
        check("abort_orphan", err_orphan, 0);
        d0 = n_done;
        run_row(5, 100, 100, -1, sent);
        wait_idle(100);
        check("after_abort_done", n_done - d0, 1);

        // abort while draining
        run_row(6, 100, 50, -1, sent);
        abort = 1'b1;
        step();
        wait_idle(100);

        // random rows
        for (int r = 0; r < 14; r++) begin
            n = $urandom_range(1, 50);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n-1)
                                             : -1;
            run_row(n, $urandom_range(30, 100),
                    $urandom_range(20, 100), ab, sent);
            wait_idle($urandom_range(30, 100));
        end

        // orphan result while idle
        repeat (30) step();
        inj = 1'b1;
        inj_err = DW'($urandom);
        step();
        @(negedge clk);
        check("orphan_set", err_orphan, 1);
        check("orphan_res_vld", bus.res_vld, 0);
        repeat (10) step();
        @(negedge clk);
        check("orphan_sticky", err_orphan, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
